lut_sweep_engine: RTL and testbench
===================================

// Module: lut_sweep_engine
// PURPOSE
//  Parametrised, registered truth-table engine: stores an OUT_CH-output function of IN_W inputs as a loadable table.
//  Provides a 1-cycle direct-evaluate port and a sweep mode.
//  Sweep mode walks all 2**IN_W input rows and streams {row, outputs} over a valid/ready handshake.
//  Replaces hand-coded sum-of-products blocks; bench and display logic consume the sweep stream.
// PARAMETERS
//  IN_W    4   number of function inputs; table holds ROWS = 2**IN_W rows
//  OUT_CH  10  number of output functions (bits per row)
// PORTS
//  clk       in   1       single clock, rising edge
//  rst       in   1       asynchronous, active-high reset
//  wr_en     in   1       table write strobe
//  wr_addr   in   IN_W    row to write
//  wr_data   in   OUT_CH  row contents, bit k = output channel k
//  eval_in   in   IN_W    direct-evaluate input vector
//  eval_out  out  OUT_CH  registered table[eval_in]
//  start     in   1       sweep request, sampled in IDLE only
//  busy      out  1       high in SWEEP and DONE
//  out_valid out  1       sweep beat valid
//  out_ready in   1       sink accepts beat
//  out_row   out  IN_W    row index of current beat
//  out_data  out  OUT_CH  table[out_row]
//  done      out  1       one-cycle pulse after the last beat is accepted
// BEHAVIOUR
//  Reset: all table rows=0, eval_out=0, state=IDLE, row=0, out_valid=0, done=0, busy=0.
//  Reset mid-sweep aborts the sweep immediately; no done pulse.
//  Write: when wr_en=1 and state=IDLE, table[wr_addr] <= wr_data at clk edge.
//  Writes while busy=1 are dropped silently.
//  Eval: eval_out <= table[eval_in] each cycle; latency 1.
//  Same-cycle write/eval of the same row returns the old contents (read-before-write).
//  FSM IDLE: start=1 -> SWEEP, row<=0.
//  FSM SWEEP: out_valid=1, out_row=row, out_data=table[row].
//   Beat values are held stable while out_ready=0.
//   On out_valid&out_ready: if row==ROWS-1 -> DONE, else row<=row+1.
//   Full throughput: one beat per cycle with out_ready tied high.
//  FSM DONE: done=1, out_valid=0 for one cycle, then -> IDLE.
//  start is ignored while busy; the row counter never wraps inside a sweep.
//  Widths: row counter is IN_W bits; terminal compare against all-ones, no extra bit.
// CONFIGURATION
//  LUT_SWEEP_PARITY_EN defined:
//   - Each table row stores an extra even-parity bit computed on write.
//   - Parity is checked on every eval read and every sweep beat.
//   - A mismatch sets output par_err (1 bit, sticky; cleared only by rst).
//   - Mismatching data is still output unchanged.
//  LUT_SWEEP_PARITY_EN not defined: no parity storage, no par_err port; behaviour otherwise identical.
// STRUCTURE
//  Package lut_sweep_pkg:
//   - state enum {IDLE, SWEEP, DONE}
//   - function rows(in_w) = 1<<in_w
//   - parity helper function
//  Sub-module lut_table_mem:
//   - ROWS x OUT_CH(+1) flop array with async clear
//   - one write port and two combinational read ports (eval, sweep)
//  Top level holds the FSM, the row counter and the eval output register.
// TESTING
//  1 Load row i = {i==3||i>=13 ...} i.e. a 10-channel pattern, wr_data=i*37%1024, rows 0..15; eval_in=5
//    -> eval_out=185 one cycle later.
//  2 start with out_ready=1 -> 16 beats on 16 consecutive cycles, out_row 0..15 with matching data.
//    -> done pulses the cycle after row 15; busy low the cycle after that.
//  3 Backpressure: out_ready toggles 1,0,0,1,... -> no beat lost or duplicated; out_row/out_data stable while stalled.
//  4 start pulsed and wr_en (addr 2, data 0x3FF) issued mid-sweep
//    -> no restart, row 2 unchanged afterwards, exactly 16 beats.
//  5 rst asserted at row 7 -> out_valid/busy drop asynchronously, table reads 0, no done.
//    -> a new start sweeps all 16 zero rows.
//  6 (LUT_SWEEP_PARITY_EN) force-flip a stored bit of row 9, then sweep
//    -> par_err rises on beat 9 and stays high until rst.

Source files
------------

// File: rtl/lut_sweep_pkg.sv
// Shared types and helpers for the LUT sweep engine.
// LUT_SWEEP_PARITY_EN adds one even-parity bit per stored row.
package lut_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_e;

`ifdef LUT_SWEEP_PARITY_EN
   localparam int PAR_W = 1;
`else
   localparam int PAR_W = 0;
`endif

   function automatic int rows(input int in_w);
      return 1 << in_w;
   endfunction

   // Bit that makes the total number of ones (data plus this bit) even.
   function automatic logic even_par(input logic [63:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/lut_sweep_if.sv
// Table-load, evaluate and sweep-stream signals of the LUT sweep engine.
// par_err exists only when LUT_SWEEP_PARITY_EN is defined.
interface lut_sweep_if #(
   parameter int IN_W   = 4,
   parameter int OUT_CH = 10
);
   logic              wr_en;
   logic [IN_W-1:0]   wr_addr;
   logic [OUT_CH-1:0] wr_data;
   logic [IN_W-1:0]   eval_in;
   logic [OUT_CH-1:0] eval_out;
   logic              start;
   logic              busy;
   logic              out_valid;
   logic              out_ready;
   logic [IN_W-1:0]   out_row;
   logic [OUT_CH-1:0] out_data;
   logic              done;
`ifdef LUT_SWEEP_PARITY_EN
   logic              par_err;
`endif

   modport master (
      output wr_en, wr_addr, wr_data, eval_in, start, out_ready,
      input  eval_out, busy, out_valid, out_row, out_data, done
`ifdef LUT_SWEEP_PARITY_EN
      , par_err
`endif
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, eval_in, start, out_ready,
      output eval_out, busy, out_valid, out_row, out_data, done
`ifdef LUT_SWEEP_PARITY_EN
      , par_err
`endif
   );

endinterface

// File: rtl/lut_sweep_engine_mem.sv
// Truth-table storage: one write port, two combinational read ports.
// Under LUT_SWEEP_PARITY_EN each row carries a parity bit above the data.
module lut_table_mem
   import lut_sweep_pkg::*;
#(
   parameter int IN_W   = 4,
   parameter int OUT_CH = 10
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      we_i,
   input  logic [IN_W-1:0]           waddr_i,
   input  logic [OUT_CH-1:0]         wdata_i,
   input  logic [IN_W-1:0]           raddr_a_i,
   input  logic [IN_W-1:0]           raddr_b_i,
   output logic [OUT_CH+PAR_W-1:0]   rdata_a_o,
   output logic [OUT_CH+PAR_W-1:0]   rdata_b_o
);
   localparam int ROWS = rows(IN_W);
   localparam int W    = OUT_CH + PAR_W;

   logic [W-1:0] mem_q [ROWS];
   logic [W-1:0] wrow_d;

`ifdef LUT_SWEEP_PARITY_EN
   assign wrow_d = {even_par(64'(wdata_i)), wdata_i};
`else
   assign wrow_d = wdata_i;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < ROWS; r++) mem_q[r] <= '0;
      end else if (we_i) begin
         mem_q[waddr_i] <= wrow_d;
      end
   end

   assign rdata_a_o = mem_q[raddr_a_i];
   assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/lut_sweep_engine.sv
// Loadable truth-table engine: 1-cycle evaluate port plus a full-table sweep stream.
// LUT_SWEEP_PARITY_EN enables stored parity and the sticky par_err flag.
module lut_sweep_engine
   import lut_sweep_pkg::*;
#(
   parameter int IN_W   = 4,
   parameter int OUT_CH = 10
) (
   input logic        clk,
   input logic        rst,
   lut_sweep_if.slave bus
);
   localparam int              W        = OUT_CH + PAR_W;
   localparam logic [IN_W-1:0] LAST_ROW = {IN_W{1'b1}};

   state_e            state_q;
   logic [IN_W-1:0]   row_q;
   logic              out_valid_q;
   logic              busy_q;
   logic              done_q;
   logic [OUT_CH-1:0] eval_out_q;
   logic [OUT_CH-1:0] eval_out_d;
   logic [W-1:0]      eval_rd;
   logic [W-1:0]      sweep_rd;
   logic              wr_ok;

   // Table is frozen for the whole sweep so the stream is a consistent snapshot.
   assign wr_ok = bus.wr_en && (state_q == IDLE);

   lut_table_mem #(
      .IN_W   (IN_W),
      .OUT_CH (OUT_CH)
   ) u_mem (
      .clk       (clk),
      .rst       (rst),
      .we_i      (wr_ok),
      .waddr_i   (bus.wr_addr),
      .wdata_i   (bus.wr_data),
      .raddr_a_i (bus.eval_in),
      .raddr_b_i (row_q),
      .rdata_a_o (eval_rd),
      .rdata_b_o (sweep_rd)
   );

   assign eval_out_d = eval_rd[OUT_CH-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) eval_out_q <= '0;
      else     eval_out_q <= eval_out_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         row_q       <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_q     <= SWEEP;
                  row_q       <= '0;
                  out_valid_q <= 1'b1;
                  busy_q      <= 1'b1;
               end
            end
            SWEEP: begin
               if (bus.out_ready) begin
                  if (row_q == LAST_ROW) begin
                     state_q     <= DONE;
                     out_valid_q <= 1'b0;
                     done_q      <= 1'b1;
                  end else begin
                     row_q <= row_q + 1'b1;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.eval_out  = eval_out_q;
   assign bus.busy      = busy_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_row   = row_q;
   assign bus.out_data  = sweep_rd[OUT_CH-1:0];
   assign bus.done      = done_q;

`ifdef LUT_SWEEP_PARITY_EN
   logic par_err_q;

   // A stored row with odd total parity has been corrupted since it was written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) par_err_q <= 1'b0;
      else if ((^eval_rd) || (out_valid_q && (^sweep_rd))) par_err_q <= 1'b1;
   end

   assign bus.par_err = par_err_q;
`endif

endmodule

// File: tb/tb_lut_sweep_engine.sv
// Scoreboard bench for lut_sweep_engine: stimulus queues expected beats, a monitor pops them.
module tb_lut_sweep_engine;
   import lut_sweep_pkg::*;

   localparam int IN_W   = 4;
   localparam int OUT_CH = 10;
   localparam int ROWS   = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lut_sweep_if #(.IN_W(IN_W), .OUT_CH(OUT_CH)) bus ();

   lut_sweep_engine #(.IN_W(IN_W), .OUT_CH(OUT_CH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int cyc      = 0;
   int done_cnt = 0;
   int beats    = 0;
   int first_cyc = 0;
   int last_cyc  = 0;
   int done_cyc  = 0;
   int bp_k      = 0;
   int d0;
   int n;
   logic bp_mode   = 1'b0;
   logic prev_done = 1'b0;
   logic [OUT_CH-1:0]      tbl [ROWS];
   logic [IN_W+OUT_CH-1:0] exp_q [$];
   logic [IN_W+OUT_CH-1:0] mon_exp;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      chk_cnt++;
      if (act === expv) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
   endtask

   // Sink ready: tied high, or the repeating 1,0,0 backpressure pattern.
   always @(posedge clk) begin
      #1;
      if (bp_mode) begin
         bus.out_ready = ((bp_k % 3) == 0);
         bp_k++;
      end else begin
         bus.out_ready = 1'b1;
      end
   end

   // Monitor: every presented beat is compared against the head of the queue.
   always @(negedge clk) begin
      if (prev_done) check("busy_after_done", 32'(bus.busy), 32'd0);
      prev_done = 1'b0;
      if (!rst && bus.out_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat_row", 32'(bus.out_row), 32'hFFFF_FFFF);
         end else if (bus.out_ready) begin
            mon_exp = exp_q.pop_front();
            check("beat", 32'({bus.out_row, bus.out_data}), 32'(mon_exp));
            if (beats == 0) first_cyc = cyc;
            last_cyc = cyc;
            beats++;
         end else begin
            check("stall_hold", 32'({bus.out_row, bus.out_data}), 32'(exp_q[0]));
         end
      end
      if (!rst && bus.done) begin
         done_cnt++;
         done_cyc  = cyc;
         prev_done = 1'b1;
         check("done_beats", 32'(beats), 32'd16);
         check("done_valid_low", 32'(bus.out_valid), 32'd0);
         check("done_busy_high", 32'(bus.busy), 32'd1);
      end
   end

   task automatic push_all();
      beats = 0;
      for (int i = 0; i < ROWS; i++) exp_q.push_back({4'(i), tbl[i]});
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int base);
      int k = 0;
      while (done_cnt == base && k < 400) begin
         @(posedge clk);
         k++;
      end
      check("sweep_done", 32'(done_cnt - base), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic write_row(input int a, input logic [OUT_CH-1:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = 4'(a);
      bus.wr_data = d;
      @(posedge clk); #1;
      bus.wr_en   = 1'b0;
   endtask

   task automatic eval_check(input string name, input int a, input logic [OUT_CH-1:0] expv);
      bus.eval_in = 4'(a);
      @(posedge clk); #1;
      check(name, 32'(bus.eval_out), 32'(expv));
   endtask

   initial begin
      rst         = 1'b1;
      bus.wr_en   = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.eval_in = '0;
      bus.start   = 1'b0;
      #2;
      check("rst_eval_out", 32'(bus.eval_out), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Load row i with i*37 mod 1024.
      for (int i = 0; i < ROWS; i++) begin
         tbl[i] = 10'((i * 37) % 1024);
         write_row(i, tbl[i]);
      end
      eval_check("eval_row5", 5, 10'd185);
      eval_check("eval_row12", 12, 10'd444);
      eval_check("eval_row15", 15, 10'd555);

      // Same-cycle write and eval of row 3 returns the old contents first.
      bus.eval_in = 4'd3;
      bus.wr_en   = 1'b1;
      bus.wr_addr = 4'd3;
      bus.wr_data = 10'h155;
      @(posedge clk); #1;
      bus.wr_en = 1'b0;
      check("eval_rbw_old", 32'(bus.eval_out), 32'd111);
      @(posedge clk); #1;
      check("eval_rbw_new", 32'(bus.eval_out), 32'h155);
      tbl[3] = 10'h155;

      // Full-throughput sweep.
      push_all();
      d0 = done_cnt;
      pulse_start();
      wait_done(d0);
      check("burst_span", 32'(last_cyc - first_cyc), 32'd15);
      check("done_lag", 32'(done_cyc - last_cyc), 32'd1);

      // Backpressure sweep.
      bp_k    = 0;
      bp_mode = 1'b1;
      push_all();
      d0 = done_cnt;
      pulse_start();
      wait_done(d0);
      bp_mode = 1'b0;
      check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

      // Start and write issued mid-sweep are both ignored.
      push_all();
      d0 = done_cnt;
      pulse_start();
      repeat (4) @(posedge clk);
      #1;
      bus.start   = 1'b1;
      bus.wr_en   = 1'b1;
      bus.wr_addr = 4'd2;
      bus.wr_data = 10'h3FF;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
      wait_done(d0);
      repeat (3) @(posedge clk);
      #1;
      check("no_restart_busy", 32'(bus.busy), 32'd0);
      check("no_restart_done", 32'(done_cnt - d0), 32'd1);
      eval_check("row2_unchanged", 2, 10'd74);

      // Reset while row 7 is presented aborts the sweep.
      push_all();
      d0 = done_cnt;
      pulse_start();
      n = 0;
      while (!(bus.out_valid && bus.out_row == 4'd7) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("reached_row7", 32'(bus.out_row), 32'd7);
      #1;
      rst = 1'b1;
      #1;
      check("abort_valid", 32'(bus.out_valid), 32'd0);
      check("abort_busy", 32'(bus.busy), 32'd0);
      exp_q.delete();
      for (int i = 0; i < ROWS; i++) tbl[i] = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      eval_check("cleared_row9", 9, 10'd0);
      eval_check("cleared_row14", 14, 10'd0);
      repeat (3) @(posedge clk);
      #1;
      check("no_done_on_abort", 32'(done_cnt - d0), 32'd0);
      push_all();
      d0 = done_cnt;
      pulse_start();
      wait_done(d0);

`ifdef LUT_SWEEP_PARITY_EN
      // Corrupt row 9 behind the write port so its stored parity no longer matches.
      bus.eval_in = 4'd0;
      @(posedge clk); #1;
      check("par_err_clear", 32'(bus.par_err), 32'd0);
      force dut.u_mem.mem_q[9] = 11'h001;
      #1;
      release dut.u_mem.mem_q[9];
      tbl[9] = 10'h001;
      push_all();
      d0 = done_cnt;
      pulse_start();
      wait_done(d0);
      check("par_err_sticky", 32'(bus.par_err), 32'd1);
      rst = 1'b1;
      #1;
      check("par_err_rst", 32'(bus.par_err), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
`endif

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
